// File: rtl/layer3_result_reader_pkg.sv
// Shared types and constants for the layer-3 result reader: map geometry, beat payload, FSM encoding.
package layer3_result_reader_pkg;

  localparam int unsigned LAYER3_OUTPUT_LENGTH = 128;
  localparam int unsigned MAP_W      = 14;
  localparam int unsigned PAD_W      = 16;
  localparam int unsigned FIFO_DEPTH = 3;
  localparam int unsigned COORD_W    = 5;
  localparam int unsigned ADDR_W     = 16;
  localparam int unsigned CNT_W      = 2;

  typedef logic [LAYER3_OUTPUT_LENGTH-1:0] l3_data_t;
  typedef logic [COORD_W-1:0]              coord_t;

  typedef struct packed {
    l3_data_t data;
    coord_t   row;
    coord_t   col;
    logic     last;
  } beat_t;

  // FSM encoding
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_RUN   = 2'd1;
  localparam state_t ST_DRAIN = 2'd2;

  // Sweep coordinate -> memory coordinate; padded sweeps are offset by one and clamped into the map.
  function automatic logic [ADDR_W-1:0] mem_coord(input coord_t c, input logic padded);
    if (!padded)                return ADDR_W'(c);
    if (c == '0)                return '0;
    if (c > COORD_W'(MAP_W))    return ADDR_W'(MAP_W - 1);
    return ADDR_W'(c - COORD_W'(1));
  endfunction

endpackage

// File: rtl/layer3_result_reader_if.sv
// Output beat stream of the layer-3 result reader (valid/ready with coordinate sideband).
interface layer3_result_reader_if;
  import layer3_result_reader_pkg::*;

  logic     out_valid;
  logic     out_ready;
  l3_data_t out_data;
  coord_t   out_row;
  coord_t   out_col;
  logic     out_last;

  modport master (output out_valid, out_data, out_row, out_col, out_last, input out_ready);
  modport slave  (input out_valid, out_data, out_row, out_col, out_last, output out_ready);
endinterface

// File: rtl/layer3_reader_fifo.sv
// Three-entry shifting beat FIFO; entry 0 is always the head so the head payload comes straight from a register.
module layer3_reader_fifo
  import layer3_result_reader_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  beat_t            push_beat,
  input  logic             pop,
  output beat_t            head,
  output logic             not_empty,
  output logic [CNT_W-1:0] count
);

  beat_t            mem [FIFO_DEPTH];
  logic [CNT_W-1:0] count_nxt;
  logic [CNT_W-1:0] wr_idx;

  always_comb begin
    count_nxt = count;
    if (push && !pop)      count_nxt = count + CNT_W'(1);
    else if (!push && pop) count_nxt = count - CNT_W'(1);
    wr_idx = pop ? (count - CNT_W'(1)) : count;
  end

  // Pop shifts toward the head; a simultaneous push lands behind the surviving entries.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      count     <= '0;
      not_empty <= 1'b0;
    end else begin
      if (pop) begin
        for (int i = 0; i < FIFO_DEPTH - 1; i++) mem[i] <= mem[i+1];
      end
      if (push) mem[wr_idx] <= push_beat;
      count     <= count_nxt;
      not_empty <= (count_nxt != '0);
    end
  end

  assign head = mem[0];

endmodule

// File: rtl/layer3_result_reader.sv
// Streams the layer-3 result map from memory as raster-ordered beats.
// Define LAYER3_READER_PAD_EN for a 16x16 sweep with a zero border around the 14x14 map.
module layer3_result_reader
  import layer3_result_reader_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  output logic [ADDR_W-1:0]      read_row_addr,
  output logic [ADDR_W-1:0]      read_col_addr,
  output logic                   layer3_result_read_signal,
  input  l3_data_t               layer3_result_output,
  layer3_result_reader_if.master stream
);

`ifdef LAYER3_READER_PAD_EN
  localparam int unsigned SWEEP_W = PAD_W;
  localparam logic        PADDED  = 1'b1;
`else
  localparam int unsigned SWEEP_W = MAP_W;
  localparam logic        PADDED  = 1'b0;
`endif
  localparam coord_t      LAST_C = COORD_W'(SWEEP_W - 1);
  localparam int unsigned OCC_W  = CNT_W + 1;

  state_t              state, state_nxt;
  coord_t              row_q, col_q, row_nxt, col_nxt;
  logic [ADDR_W-1:0]   row_addr_nxt, col_addr_nxt;
  logic                issue, done_nxt, border, at_end, pop;
  logic [OCC_W-1:0]    occupancy;
  logic                pend_valid, pend_last, pend_pad;
  coord_t              pend_row, pend_col;
  beat_t               push_beat, head;
  logic                fifo_not_empty;
  logic [CNT_W-1:0]    fifo_count;

  assign at_end    = (row_q == LAST_C) && (col_q == LAST_C);
  assign border    = PADDED && ((row_q == '0) || (row_q == LAST_C) || (col_q == '0) || (col_q == LAST_C));
  assign occupancy = {1'b0, fifo_count} + OCC_W'(pend_valid);
  assign pop       = fifo_not_empty && stream.out_ready;

  always_comb begin
    state_nxt    = state;
    row_nxt      = row_q;
    col_nxt      = col_q;
    row_addr_nxt = read_row_addr;
    col_addr_nxt = read_col_addr;
    issue        = 1'b0;
    done_nxt     = 1'b0;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_RUN;
      ST_RUN: begin
        if (occupancy < OCC_W'(FIFO_DEPTH)) begin
          issue = 1'b1;
          if (at_end) begin
            state_nxt = ST_DRAIN;
          end else begin
            if (col_q == LAST_C) begin
              col_nxt = '0;
              row_nxt = row_q + COORD_W'(1);
            end else begin
              col_nxt = col_q + COORD_W'(1);
            end
            row_addr_nxt = mem_coord(row_nxt, PADDED);
            col_addr_nxt = mem_coord(col_nxt, PADDED);
          end
        end
      end
      ST_DRAIN: begin
        // Only the last beat remains and it is leaving this cycle.
        if (pop && head.last && (fifo_count == CNT_W'(1)) && !pend_valid) begin
          state_nxt    = ST_IDLE;
          done_nxt     = 1'b1;
          row_nxt      = '0;
          col_nxt      = '0;
          row_addr_nxt = '0;
          col_addr_nxt = '0;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state                     <= ST_IDLE;
      row_q                     <= '0;
      col_q                     <= '0;
      read_row_addr             <= '0;
      read_col_addr             <= '0;
      busy                      <= 1'b0;
      done                      <= 1'b0;
      layer3_result_read_signal <= 1'b0;
    end else begin
      state                     <= state_nxt;
      row_q                     <= row_nxt;
      col_q                     <= col_nxt;
      read_row_addr             <= row_addr_nxt;
      read_col_addr             <= col_addr_nxt;
      busy                      <= (state_nxt != ST_IDLE);
      done                      <= done_nxt;
      layer3_result_read_signal <= (state_nxt != ST_IDLE);
    end
  end

  // One-cycle read pipeline: tags follow the issued coordinate until the memory data arrives.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_valid <= 1'b0;
      pend_row   <= '0;
      pend_col   <= '0;
      pend_last  <= 1'b0;
      pend_pad   <= 1'b0;
    end else begin
      pend_valid <= issue;
      if (issue) begin
        pend_row  <= row_q;
        pend_col  <= col_q;
        pend_last <= at_end;
        pend_pad  <= border;
      end
    end
  end

  always_comb begin
    push_beat.data = pend_pad ? '0 : layer3_result_output;
    push_beat.row  = pend_row;
    push_beat.col  = pend_col;
    push_beat.last = pend_last;
  end

  layer3_reader_fifo u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (pend_valid),
    .push_beat (push_beat),
    .pop       (pop),
    .head      (head),
    .not_empty (fifo_not_empty),
    .count     (fifo_count)
  );

  assign stream.out_valid = fifo_not_empty;
  assign stream.out_data  = head.data;
  assign stream.out_row   = head.row;
  assign stream.out_col   = head.col;
  assign stream.out_last  = head.last;

endmodule
